// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants for the bit-serial adder: default operand width and FSM state encodings.
// Revision 1.0
`default_nettype none

package serial_adder_ctrl_pkg;

  localparam int DEFAULT_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_adder_ctrl_adder_1bit.sv
// Single-bit full adder shared by every bit position of the serial adder.
// Revision 1.0
`default_nettype none

module adder_1bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// Bit-serial a + b + cin, LSB first, one bit per clock through one shared full adder.
// Revision 1.0
`default_nettype none

module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           load;
  logic           last_bit;
  logic           fa_s;
  logic           fa_co;

  adder_1bit u_fa (
    .x  (op_a[0]),
    .y  (op_b[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        // Back-to-back issue: a start seen in DONE skips the IDLE cycle.
        if (start) begin
          state_next = RUN;
          load       = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      // sum is deliberately left alone so the previous result stays visible.
      op_a  <= a;
      op_b  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      sum   <= {fa_s, sum[N-1:1]};
      carry <= fa_co;
      if (last_bit) begin
        cout <= fa_co;
        ovf  <= carry ^ fa_co;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (N=8): directed vectors plus a random sweep.
// Revision 1.0
`default_nettype none

module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];

  serial_adder_ctrl #(.N(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Expected {ovf, cout, sum}: signed overflow when same-sign operands give a different-sign result.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] t;
    logic       o;
    t = {1'b0, x} + {1'b0, y} + {8'd0, c};
    o = (x[7] == y[7]) && (t[7] != x[7]);
    return {o, t};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("result", {22'd0, ovf, cout, sum}, {22'd0, e});
      end
    end
  end

  // Issue one operation from the current negedge; optional mid-run start glitch and hold check.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        input int glitch_at, input bit chk_hold, input logic [7:0] hold_val);
    int  nb;
    bit  got;
    exp_q.push_back(model(ia, ib, ic));
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (chk_hold) check("sum_hold_first_run", {24'd0, sum}, {24'd0, hold_val});
    nb  = 0;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin got = 1; break; end
      if (busy) nb++;
      if (glitch_at != 0 && nb == glitch_at && busy) begin
        start = 1'b1; a = ~ia; b = 8'h55; cin = ~ic;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", {31'd0, got}, 1);
    check("busy_cycles", nb, 8);
  endtask

  logic [9:0] ref_v;

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs", {27'd0, busy, done, cout, ovf, 1'b0} | {24'd0, sum}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", {27'd0, busy, done, cout, ovf, 1'b0} | {24'd0, sum}, 0);

    run_op(8'h5A, 8'h3C, 1'b0, 0, 0, 8'h00);
    @(negedge clk);
    run_op(8'hFF, 8'h01, 1'b0, 0, 0, 8'h00);
    @(negedge clk);
    run_op(8'h7F, 8'h00, 1'b1, 0, 0, 8'h00);
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("idle_hold", {22'd0, ovf, cout, sum}, {22'd0, model(8'h7F, 8'h00, 1'b1)});

    // Start pulsed with different operands in RUN cycle 4 must be ignored.
    run_op(8'h12, 8'h34, 1'b1, 4, 0, 8'h00);
    @(negedge clk);
    check("idle_after_glitch", {30'd0, busy, done}, 0);

    // Reset during RUN cycle 3.
    a = 8'hAB; b = 8'hCD; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_before_abort", {31'd0, busy}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_outputs", {27'd0, busy, done, cout, ovf, 1'b0} | {24'd0, sum}, 0);
    @(negedge clk);
    run_op(8'h10, 8'h20, 1'b0, 0, 0, 8'h00);

    // Back-to-back from DONE: previous sum 0x30 held until the first RUN edge.
    run_op(8'h01, 8'h01, 1'b0, 0, 1, 8'h30);
    run_op(8'h80, 8'h80, 1'b1, 0, 1, 8'h02);
    @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, 0, 0, 8'h00);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    ref_v = model(8'h00, 8'h00, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
